phase_delay_scheduler: RTL and testbench

- Round-robin scheduler that shares one programmable delay counter among NUM_CH phase-delay requesters on the QCM phase delay board.
- Each requester presents a request and its own delay value in clock cycles.
- The scheduler grants one requester at a time, counts out that requester's delay, then returns a fixed-width done pulse to that requester only.
- Sits between the trigger/zero-crossing logic and the per-channel output drivers.

---
 rtl/phase_delay_scheduler.sv | 116 +++++++++++
 tb/tb_phase_delay_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_delay_scheduler.sv
// Round-robin scheduler sharing one programmable delay counter among NUM_CH phase-delay requesters.
// Optional abort input enabled by defining PHASE_DELAY_SCHED_ABORT_EN.
module phase_delay_scheduler #(
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned CH_BITS      = 2,
   parameter int unsigned COUNTER_SIZE = 5,
   parameter int unsigned DONE_WIDTH   = 3
) (
   input  logic                           clk,
   input  logic                           rst,
`ifdef PHASE_DELAY_SCHED_ABORT_EN
   input  logic                           abort,
`endif
   input  logic [NUM_CH-1:0]              req,
   input  logic [NUM_CH*COUNTER_SIZE-1:0] delay_in,
   output logic [NUM_CH-1:0]              grant,
   output logic [NUM_CH-1:0]              done,
   output logic                           busy,
   output logic [CH_BITS-1:0]             active_ch
);

   localparam int unsigned DW_BITS = 3;

   typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

   state_t                  state_q, state_d;
   logic [CH_BITS-1:0]      last_q;
   logic [CH_BITS-1:0]      win_idx;
   logic [CH_BITS-1:0]      cand;
   logic                    win_found;
   logic [COUNTER_SIZE-1:0] delay_q;
   logic [COUNTER_SIZE-1:0] cnt_q;
   logic [DW_BITS-1:0]      dcnt_q;
   logic                    abort_hit;
   logic [COUNTER_SIZE-1:0] dly_arr [NUM_CH];

`ifdef PHASE_DELAY_SCHED_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_slice
      assign dly_arr[g] = delay_in[g*COUNTER_SIZE +: COUNTER_SIZE];
   end

   function automatic logic [NUM_CH-1:0] onehot(input logic [CH_BITS-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   // Round-robin search starting just after the last served channel.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         cand = CH_BITS'((32'(last_q) + i) % NUM_CH);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Abort takes priority over the COUNT->DONE transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (win_found) state_d = LOAD;
         LOAD: begin
            if (abort_hit)                    state_d = IDLE;
            else if (delay_q != '0)           state_d = COUNT;
            else                              state_d = DONE;
         end
         COUNT: begin
            if (abort_hit)                                     state_d = IDLE;
            else if (cnt_q == delay_q - COUNTER_SIZE'(1))      state_d = DONE;
         end
         DONE:  if (dcnt_q == DW_BITS'(DONE_WIDTH - 1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered outputs, all driven from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q    <= CH_BITS'(NUM_CH - 1);
         active_ch <= '0;
         delay_q   <= '0;
         cnt_q     <= '0;
         dcnt_q    <= '0;
         grant     <= '0;
         done      <= '0;
         busy      <= 1'b0;
      end else begin
         grant <= (state_q == IDLE && win_found) ? onehot(win_idx) : '0;
         done  <= (state_d == DONE) ? onehot(active_ch) : '0;
         busy  <= (state_d != IDLE);
         if (state_q == IDLE && win_found) begin
            active_ch <= win_idx;
            delay_q   <= dly_arr[win_idx];
            cnt_q     <= '0;
         end
         if (state_q == LOAD)  last_q <= active_ch;
         if (state_q == COUNT) cnt_q  <= cnt_q + COUNTER_SIZE'(1);
         dcnt_q <= (state_q == DONE) ? dcnt_q + DW_BITS'(1) : '0;
      end
   end

endmodule

// File: tb/tb_phase_delay_scheduler.sv
// Self-checking bench for phase_delay_scheduler: vector table, corner sequences, randomized run vs a transaction-level model.
module tb_phase_delay_scheduler;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CH_BITS = 2;
   localparam int unsigned CS = 5;
   localparam int unsigned DW = 3;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    abort_s = 1'b0;
   logic [NUM_CH-1:0]       req = '0;
   logic [NUM_CH*CS-1:0]    delay_in = '0;
   logic [NUM_CH-1:0]       grant, done;
   logic                    busy;
   logic [CH_BITS-1:0]      active_ch;

   always #5 clk = ~clk;

   phase_delay_scheduler #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .COUNTER_SIZE(CS), .DONE_WIDTH(DW)) dut (
      .clk(clk),
      .rst(rst),
`ifdef PHASE_DELAY_SCHED_ABORT_EN
      .abort(abort_s),
`endif
      .req(req),
      .delay_in(delay_in),
      .grant(grant),
      .done(done),
      .busy(busy),
      .active_ch(active_ch)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Transaction model: one service spans cycles m_t (grant) .. m_end (last done cycle).
   bit m_valid, m_abort;
   int m_t, m_end, m_d, m_ch, m_last;

   typedef struct {
      logic [NUM_CH-1:0]    req;
      logic [NUM_CH*CS-1:0] dly;
      int                   ch;
      int                   off;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [NUM_CH*CS-1:0] pk(input int d3, input int d2, input int d1, input int d0);
      return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
   endfunction

   function automatic int oh2idx(input logic [NUM_CH-1:0] v);
      int idx = -1;
      int n = 0;
      for (int k = 0; k < NUM_CH; k++) if (v[k]) begin idx = k; n++; end
      return (n == 1) ? idx : -1;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_abort = 0; m_last = NUM_CH - 1;
      m_t = 0; m_end = -1; m_d = 0; m_ch = 0;
   endtask

   task automatic model_edge();
      bit bp;
      bit found;
      int k;
      bp = m_valid && (cyc - 1 >= m_t) && (cyc - 1 <= m_end);
      if (bp && abort_s && (cyc - 1 <= m_t + m_d)) begin
         m_end   = cyc - 1;
         m_abort = 1;
      end else if (!bp && req != '0) begin
         found = 0;
         for (int i = 1; i <= NUM_CH; i++) begin
            k = (m_last + i) % NUM_CH;
            if (!found && req[k]) begin found = 1; m_ch = k; end
         end
         m_d     = int'(delay_in[m_ch*CS +: CS]);
         m_t     = cyc;
         m_end   = cyc + m_d + DW;
         m_valid = 1;
         m_abort = 0;
         m_last  = m_ch;
      end
   endtask

   task automatic check_outputs();
      bit eb;
      int eg, ed;
      eb = m_valid && cyc >= m_t && cyc <= m_end;
      eg = (eb && cyc == m_t) ? (1 << m_ch) : 0;
      ed = (eb && !m_abort && cyc > m_t + m_d) ? (1 << m_ch) : 0;
      chk("grant", int'(grant), eg);
      chk("done", int'(done), ed);
      chk("busy", int'(busy), int'(eb));
      if (eb) chk("active_ch", int'(active_ch), m_ch);
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      if (rst) model_reset();
      else     model_edge();
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      abort_s = 1'b0;
      step();
      chk("reset_grant", int'(grant), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_active_ch", int'(active_ch), 0);
      step();
      rst = 1'b0;
   endtask

   task automatic wait_grant(output int ch);
      int n = 0;
      step();
      while (grant == '0 && n < 20) begin step(); n++; end
      ch = oh2idx(grant);
      if (grant == '0) chk("grant_timeout", 0, 1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int ch, n, w;
      req = v.req;
      delay_in = v.dly;
      wait_grant(ch);
      chk($sformatf("vec%0d_grant_ch", idx), ch, v.ch);
      req = '0;
      n = 0;
      while (done == '0 && n < 40) begin step(); n++; end
      chk($sformatf("vec%0d_done_offset", idx), n, v.off);
      chk($sformatf("vec%0d_done_ch", idx), oh2idx(done), v.ch);
      w = 1;
      step();
      while (done != '0 && w < 10) begin w++; step(); end
      chk($sformatf("vec%0d_done_width", idx), w, DW);
      chk($sformatf("vec%0d_busy_after", idx), int'(busy), 0);
   endtask

   initial begin
      int ch, n, g;
      int exp_order[5];
      model_reset();

      vecs[0] = '{4'b0001, pk(0, 0, 0, 5),  0, 6};
      vecs[1] = '{4'b0100, pk(0, 0, 0, 0),  2, 1};
      vecs[2] = '{4'b1111, pk(4, 3, 2, 1),  3, 5};
      vecs[3] = '{4'b1111, pk(4, 3, 2, 1),  0, 2};
      vecs[4] = '{4'b1010, pk(9, 0, 7, 0),  1, 8};
      vecs[5] = '{4'b1010, pk(9, 0, 7, 0),  3, 10};
      vecs[6] = '{4'b0010, pk(0, 0, 31, 0), 1, 32};
      vecs[7] = '{4'b0001, pk(0, 0, 0, 0),  0, 1};

      do_reset();
      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // All channels held: strict rotation starting at channel 0.
      do_reset();
      exp_order = '{0, 1, 2, 3, 0};
      req = 4'b1111;
      delay_in = pk(4, 3, 2, 1);
      g = 0; n = 0;
      while (g < 5 && n < 80) begin
         step(); n++;
         if (grant != '0) begin
            chk($sformatf("rr_order%0d", g), oh2idx(grant), exp_order[g]);
            g++;
         end
      end
      chk("rr_grant_count", g, 5);
      req = '0;
      for (int i = 0; i < 12; i++) step();

      // Asynchronous reset in the middle of a count.
      do_reset();
      req = 4'b0010;
      delay_in = pk(0, 0, 10, 0);
      wait_grant(ch);
      chk("rst_seq_grant_ch", ch, 1);
      req = '0;
      for (int i = 0; i < 3; i++) step();
      #3 rst = 1'b1;
      #1;
      model_reset();
      chk("async_rst_grant", int'(grant), 0);
      chk("async_rst_done", int'(done), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_active_ch", int'(active_ch), 0);
      step();
      rst = 1'b0;
      req = 4'b0011;
      delay_in = pk(0, 0, 2, 2);
      step();
      chk("post_rst_grant", int'(grant), 1);
      req = '0;
      for (int i = 0; i < 15; i++) step();

`ifdef PHASE_DELAY_SCHED_ABORT_EN
      do_reset();
      req = 4'b1000;
      delay_in = pk(10, 0, 0, 3);
      wait_grant(ch);
      chk("abort_seq_grant_ch", ch, 3);
      req = 4'b0001;
      for (int i = 0; i < 4; i++) step();
      abort_s = 1'b1;
      step();
      abort_s = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      step();
      chk("abort_next_grant", int'(grant), 1);
      req = '0;
      for (int i = 0; i < 10; i++) step();
`endif

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 2500; i++) begin
         req = ($urandom_range(0, 3) == 0) ? '0 : NUM_CH'($urandom);
         for (int k = 0; k < NUM_CH; k++)
            delay_in[k*CS +: CS] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 4));
`ifdef PHASE_DELAY_SCHED_ABORT_EN
         abort_s = ($urandom_range(0, 15) == 0);
`endif
         rst = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0;
      abort_s = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
